// File: rtl/ibus_sram_responder.sv
// ibus_sram_responder: ibus responder over a 1-cycle sync SRAM with LATENCY wait cycles; define IBUS_HIT_BYPASS_EN for the last-hit bypass
package ibus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ibus_sram_responder
  import ibus_pkg::*;
#(
  parameter int AW      = 14,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  ibus_req_t       ireq,
  output ibus_resp_t      iresp,
  output logic            mem_en,
  output logic [AW-1:0]   mem_addr,
  input  logic [31:0]     mem_rdata,
  input  logic            inval
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_RESP} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] data_q;
  logic [31:0] addr_q;
  logic        accept;
  logic        hit;
  logic [31:0] hit_data;
  logic        unused;
  assign accept   = !reset && state_q == S_IDLE && ireq.valid;
  assign mem_en   = accept && !hit;
  assign mem_addr = ireq.addr[AW+1:2];
  assign iresp.addr_ok = !reset && state_q == S_IDLE;
  assign iresp.data_ok = !reset && state_q == S_RESP;
  assign iresp.data    = reset ? '0 : data_q;
`ifdef IBUS_HIT_BYPASS_EN
  logic [29:0] last_addr_q;
  logic [31:0] last_data_q;
  logic        last_valid_q;
  assign hit      = last_valid_q && ireq.addr[31:2] == last_addr_q && !inval;
  assign hit_data = last_data_q;
  assign unused   = ^{ireq.addr[1:0], addr_q[1:0]};
  // an inval in the same cycle as a record still leaves the record invalid
  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr_q  <= '0;
      last_data_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      if (state_q == S_RESP) begin
        last_addr_q <= addr_q[31:2];
        last_data_q <= data_q;
      end
      last_valid_q <= !inval && (last_valid_q || state_q == S_RESP);
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
  assign unused   = ^{inval, addr_q, ireq.addr[1:0], ireq.addr[31:AW+2], hit_data};
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (ireq.valid) begin
          addr_q  <= ireq.addr;
          state_q <= hit ? S_RESP : S_READ;
          if (hit) data_q <= hit_data;
        end
        S_READ: begin
          data_q  <= mem_rdata;
          cnt_q   <= 4'(LATENCY);
          state_q <= LATENCY > 0 ? S_WAIT : S_RESP;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= S_RESP;
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ibus_sram_responder.sv
// tb_ibus_sram_responder: directed vector table plus randomized run against a countdown reference model, LATENCY 2 and 0
module tb_ibus_sram_responder;
  import ibus_pkg::*;
  localparam int AW = 14;
  logic      clk;
  logic      rst;
  logic      inval;
  ibus_req_t ireq;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [0:(1<<AW)-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] w(int i);
    return i == 16 ? 32'h2402_0001 : (32'h9e37_79b9 * 32'(i + 1)) ^ 32'h5a5a_0000;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int LAT = (g == 0) ? 2 : 0;
    ibus_resp_t    resp;
    logic          men;
    logic [AW-1:0] maddr;
    logic [31:0]   rdata;
    ibus_sram_responder #(.AW(AW), .LATENCY(LAT)) dut (
      .clk(clk), .reset(rst), .ireq(ireq), .iresp(resp),
      .mem_en(men), .mem_addr(maddr), .mem_rdata(rdata), .inval(inval)
    );
    always @(posedge clk) if (men) rdata <= mem[maddr];
    bit          busy = 0, lv = 0, acc, hit;
    int          left = 0;
    logic [31:0] xd = '0, ld = '0;
    logic [29:0] la = '0, wa = '0;
    // reference: a request owns the port until its response cycle; response due LAT+2 cycles after accept
    always @(negedge clk) begin
      #2;
`ifdef IBUS_HIT_BYPASS_EN
      hit = lv && ireq.valid && ireq.addr[31:2] == la && !inval;
`else
      hit = 1'b0;
`endif
      acc = !rst && !busy && ireq.valid;
      chk($sformatf("m%0d.addr_ok", g), 32'(resp.addr_ok), 32'(!rst && !busy));
      chk($sformatf("m%0d.data_ok", g), 32'(resp.data_ok), 32'(!rst && busy && left == 0));
      chk($sformatf("m%0d.mem_en", g), 32'(men), 32'(acc && !hit));
      if (acc && !hit) chk($sformatf("m%0d.mem_addr", g), 32'(maddr), 32'(ireq.addr[AW+1:2]));
      if (rst) chk($sformatf("m%0d.rst_data", g), resp.data, 32'h0);
      else if (busy && left == 0) chk($sformatf("m%0d.data", g), resp.data, xd);
      if (rst) begin
        busy = 0;
        lv = 0;
      end else begin
        if (busy && left == 0) begin
          busy = 0;
          la = wa;
          ld = xd;
          lv = 1;
        end else if (busy) left--;
        if (acc) begin
          busy = 1;
          left = hit ? 0 : LAT + 1;
          xd = hit ? ld : mem[ireq.addr[AW+1:2]];
          wa = ireq.addr[31:2];
        end
        if (inval) lv = 0;
      end
    end
  end

  typedef struct {
    bit            r;
    bit            vl;
    logic [31:0]   a;
    bit            aok;
    bit            dok;
    bit            men;
    logic [AW-1:0] ma;
    bit            cd;
    logic [31:0]   d;
  } vec_t;

  function automatic vec_t v(bit r, bit vl, logic [31:0] a, bit aok, bit dok, bit men,
                             logic [AW-1:0] ma, bit cd, logic [31:0] d);
    vec_t t;
    t.r = r; t.vl = vl; t.a = a; t.aok = aok; t.dok = dok; t.men = men; t.ma = ma; t.cd = cd; t.d = d;
    return t;
  endfunction

  task automatic drive(bit r, bit vl, logic [31:0] a, bit inv);
    @(negedge clk);
    rst = r;
    ireq.valid = vl;
    ireq.addr = a;
    inval = inv;
    #2;
  endtask

  vec_t tv[$];

  initial begin
    rst = 1'b1;
    inval = 1'b0;
    ireq = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = w(i);
    repeat (3) tv.push_back(v(1, 1, 32'hbfc0_0040, 0, 0, 0, 0, 1, 0));
    tv.push_back(v(0, 1, 32'hbfc0_0040, 1, 0, 1, 'h10, 0, 0));
    repeat (3) tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 32'h2402_0001));
    tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 1, 32'h8, 1, 0, 1, 2, 0, 0));
    repeat (3) tv.push_back(v(0, 1, 32'h100, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 1, 32'h100, 0, 1, 0, 0, 1, w(2)));
    tv.push_back(v(0, 1, 32'h100, 1, 0, 1, 'h40, 0, 0));
    repeat (3) tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, w(64)));
    tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 1, 32'h30, 1, 0, 1, 'hc, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 32'h30, 0, 0, 0, 0, 1, 0));
    tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 1, 32'h34, 1, 0, 1, 'hd, 0, 0));
    repeat (3) tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, w(13)));
    tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 1, 32'h0001_0017, 1, 0, 1, 5, 0, 0));
    repeat (3) tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, w(5)));
    repeat (2) tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].vl, tv[i].a, 0);
      chk($sformatf("v%0d.addr_ok", i), 32'(gen[0].resp.addr_ok), 32'(tv[i].aok));
      chk($sformatf("v%0d.data_ok", i), 32'(gen[0].resp.data_ok), 32'(tv[i].dok));
      chk($sformatf("v%0d.mem_en", i), 32'(gen[0].men), 32'(tv[i].men));
      if (tv[i].men) chk($sformatf("v%0d.mem_addr", i), 32'(gen[0].maddr), 32'(tv[i].ma));
      if (tv[i].cd) chk($sformatf("v%0d.data", i), gen[0].resp.data, tv[i].d);
    end
    drive(0, 1, 32'h0, 0);
    chk("l0.acc0.addr_ok", 32'(gen[1].resp.addr_ok), 1);
    drive(0, 1, 32'h4, 0);
    chk("l0.t1.addr_ok", 32'(gen[1].resp.addr_ok), 0);
    chk("l0.t1.data_ok", 32'(gen[1].resp.data_ok), 0);
    drive(0, 1, 32'h4, 0);
    chk("l0.t2.data_ok", 32'(gen[1].resp.data_ok), 1);
    chk("l0.t2.data", gen[1].resp.data, w(0));
    chk("l0.t2.addr_ok", 32'(gen[1].resp.addr_ok), 0);
    drive(0, 1, 32'h4, 0);
    chk("l0.t3.addr_ok", 32'(gen[1].resp.addr_ok), 1);
    chk("l0.t3.data_ok", 32'(gen[1].resp.data_ok), 0);
    drive(0, 0, 0, 0);
    chk("l0.t4.data_ok", 32'(gen[1].resp.data_ok), 0);
    drive(0, 0, 0, 0);
    chk("l0.t5.data_ok", 32'(gen[1].resp.data_ok), 1);
    chk("l0.t5.data", gen[1].resp.data, w(1));
    repeat (6) drive(0, 0, 0, 0);
`ifdef IBUS_HIT_BYPASS_EN
    drive(0, 1, 32'h20, 0);
    chk("bp.miss.mem_en", 32'(gen[0].men), 1);
    repeat (3) drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("bp.miss.data_ok", 32'(gen[0].resp.data_ok), 1);
    drive(0, 1, 32'h20, 0);
    chk("bp.hit.addr_ok", 32'(gen[0].resp.addr_ok), 1);
    chk("bp.hit.mem_en", 32'(gen[0].men), 0);
    drive(0, 0, 0, 0);
    chk("bp.hit.data_ok", 32'(gen[0].resp.data_ok), 1);
    chk("bp.hit.data", gen[0].resp.data, w(8));
    drive(0, 0, 0, 1);
    drive(0, 1, 32'h20, 0);
    chk("bp.inv.mem_en", 32'(gen[0].men), 1);
    repeat (3) begin
      drive(0, 0, 0, 0);
      chk("bp.inv.early", 32'(gen[0].resp.data_ok), 0);
    end
    drive(0, 0, 0, 0);
    chk("bp.inv.data_ok", 32'(gen[0].resp.data_ok), 1);
    chk("bp.inv.data", gen[0].resp.data, w(8));
    repeat (4) drive(0, 0, 0, 0);
`endif
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 99) == 0;
      inval = $urandom_range(0, 15) == 0;
      ireq.valid = $urandom_range(0, 3) != 0;
      ireq.addr = {($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0, 11'h0,
                   3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
    end
    repeat (8) drive(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
